// File: rtl/mem_responder_pkg.sv
// Shared defines for the small CPU and its program memory responder:
// memory geometry, responder FSM encodings and CPU opcode/state constants.
package mem_responder_pkg;

   localparam int MEM_DEPTH = 32;
   localparam int ADDR_W    = 5;
   localparam int DATA_W    = 8;

   // Responder FSM encodings
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LOAD = 2'd1;
   localparam logic [1:0] ST_RUN  = 2'd2;

   // Last load pointer value; accepting a byte here ends the load
   localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(MEM_DEPTH - 1);

   // CPU opcodes (upper 3 bits of IR)
   localparam logic [2:0] OP_HLT = 3'd0;
   localparam logic [2:0] OP_SKZ = 3'd1;
   localparam logic [2:0] OP_ADD = 3'd2;
   localparam logic [2:0] OP_AND = 3'd3;
   localparam logic [2:0] OP_XOR = 3'd4;
   localparam logic [2:0] OP_LDA = 3'd5;
   localparam logic [2:0] OP_STO = 3'd6;
   localparam logic [2:0] OP_JMP = 3'd7;

   // CPU controller phase encodings
   localparam logic [2:0] CPU_INST_ADDR  = 3'd0;
   localparam logic [2:0] CPU_INST_FETCH = 3'd1;
   localparam logic [2:0] CPU_INST_LOAD  = 3'd2;
   localparam logic [2:0] CPU_IDLE       = 3'd3;
   localparam logic [2:0] CPU_OP_ADDR    = 3'd4;
   localparam logic [2:0] CPU_OP_FETCH   = 3'd5;
   localparam logic [2:0] CPU_ALU_OP     = 3'd6;
   localparam logic [2:0] CPU_STORE      = 3'd7;

endpackage

// File: rtl/mem_responder.sv
// Program/data memory responder for the small CPU. A host streams a program
// in while the CPU is held in reset, then the CPU reads and writes the same
// 32 x 8 register array.
//
// state | meaning
// IDLE  | after reset; CPU held; decide between program load and run
// LOAD  | host bytes accepted into mem[ptr]; CPU held
// RUN   | CPU released; rd/wr serviced at addr
module mem_responder
   import mem_responder_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] addr,
   input  logic              rd,
   input  logic              wr,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] data_out,
   input  logic              load_en,
   input  logic              load_valid,
   input  logic [DATA_W-1:0] load_data,
   output logic              load_ready,
   output logic              load_done,
   output logic              cpu_hold,
   output logic              err
);

   logic [1:0]        state;
   logic [1:0]        state_nxt;
   logic [ADDR_W-1:0] ptr;
   logic [DATA_W-1:0] mem [MEM_DEPTH];
   logic              enter_load;
   logic              load_exit;
   logic              load_wr;
   logic              run_wr;
   logic              run_rd;
   logic              proto_err;

   // Next-state decode; also flags load entry (pointer clear) and load exit
   always_comb begin
      state_nxt  = state;
      enter_load = 1'b0;
      load_exit  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (load_en) begin
               state_nxt  = ST_LOAD;
               enter_load = 1'b1;
            end else begin
               state_nxt  = ST_RUN;
            end
         end
         ST_LOAD: begin
            if ((load_valid && (ptr == PTR_LAST)) || !load_en) begin
               state_nxt = ST_RUN;
               load_exit = 1'b1;
            end
         end
         ST_RUN: begin
            if (load_en) begin
               state_nxt  = ST_LOAD;
               enter_load = 1'b1;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // A byte offered in the same cycle load_en drops is still accepted,
   // since load_ready is high for the whole LOAD state.
   assign load_wr    = (state == ST_LOAD) && load_valid;
   assign run_wr     = (state == ST_RUN) && wr;
   assign run_rd     = (state == ST_RUN) && rd && !wr;
   assign proto_err  = (rd && wr) || ((rd || wr) && (state != ST_RUN));
   assign load_ready = (state == ST_LOAD);
   assign cpu_hold   = (state != ST_RUN);

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Load pointer: restarts at 0 on every entry into LOAD
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr <= '0;
      end else if (enter_load) begin
         ptr <= '0;
      end else if (load_wr) begin
         ptr <= ptr + 1'b1;
      end
   end

   // Completion pulse lands in the first cycle after leaving LOAD
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         load_done <= 1'b0;
      end else begin
         load_done <= load_exit;
      end
   end

   // Sticky protocol error, cleared only by reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err <= 1'b0;
      end else if (proto_err) begin
         err <= 1'b1;
      end
   end

   // Storage: reset wipes every word so an aborted load leaves nothing behind
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < MEM_DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (load_wr) begin
         mem[ptr] <= load_data;
      end else if (run_wr) begin
         mem[addr] <= data_in;
      end
   end

   // Registered read port; holds on idle cycles and on writes
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_out <= '0;
      end else if (run_rd) begin
         data_out <= mem[addr];
      end
   end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: reference memory model plus a queue of
// expected read data.
module tb_mem_responder;

   logic       clk;
   logic       rst;
   logic [4:0] addr;
   logic       rd;
   logic       wr;
   logic [7:0] data_in;
   logic [7:0] data_out;
   logic       load_en;
   logic       load_valid;
   logic [7:0] load_data;
   logic       load_ready;
   logic       load_done;
   logic       cpu_hold;
   logic       err;

   int         tests;
   int         fails;
   logic [7:0] model [32];
   logic [7:0] exp_q [$];
   logic [7:0] prev;
   int         pulses;

   mem_responder dut (
      .clk        (clk),
      .rst        (rst),
      .addr       (addr),
      .rd         (rd),
      .wr         (wr),
      .data_in    (data_in),
      .data_out   (data_out),
      .load_en    (load_en),
      .load_valid (load_valid),
      .load_data  (load_data),
      .load_ready (load_ready),
      .load_done  (load_done),
      .cpu_hold   (cpu_hold),
      .err        (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check1(input string tag, input logic obs, input logic exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < 32; i++) model[i] = 8'h00;
   endtask

   // Two-cycle fetch; data must be valid in the second rd cycle
   task automatic do_read(input logic [4:0] a, input string tag);
      addr = a;
      rd   = 1'b1;
      exp_q.push_back(model[a]);
      step();
      if (exp_q.size() == 0) begin
         tests++;
         fails++;
         $display("FAIL %s: scoreboard empty", tag);
      end else begin
         check8(tag, data_out, exp_q.pop_front());
      end
      step();
      rd = 1'b0;
   endtask

   initial begin
      tests = 0; fails = 0;
      rst = 1'b1; addr = '0; rd = 1'b0; wr = 1'b0; data_in = '0;
      load_en = 1'b0; load_valid = 1'b0; load_data = '0;
      model_clear();

      // Reset state, then straight to RUN with an all-zero memory
      step(); step();
      check1("rst_cpu_hold", cpu_hold, 1'b1);
      check1("rst_load_ready", load_ready, 1'b0);
      check1("rst_load_done", load_done, 1'b0);
      check1("rst_err", err, 1'b0);
      check8("rst_data_out", data_out, 8'h00);
      rst = 1'b0;
      step();
      check1("idle_to_run_cpu_hold", cpu_hold, 1'b0);
      for (int i = 0; i < 32; i++) do_read(5'(i), "read_zero");

      // Full 32-byte load with gaps
      load_en = 1'b1;
      step();
      check1("load_ready_in_load", load_ready, 1'b1);
      check1("cpu_hold_in_load", cpu_hold, 1'b1);
      pulses = 0;
      for (int i = 0; i < 32; i++) begin
         load_valid = 1'b1;
         load_data  = 8'hA0 + 8'(i);
         model[i]   = 8'hA0 + 8'(i);
         step();
         if (load_done) pulses++;
         load_valid = 1'b0;
         if (i == 31) load_en = 1'b0;
         if ((i % 4) == 1 && i != 31) begin
            step();
            if (load_done) pulses++;
         end
      end
      check1("load_done_after_byte32", load_done, 1'b1);
      check1("full_load_cpu_released", cpu_hold, 1'b0);
      step();
      check1("load_done_one_cycle", load_done, 1'b0);
      check8("load_done_pulse_count", 8'(pulses), 8'd1);
      do_read(5'd5, "read_a5");
      do_read(5'd0, "read_first");
      do_read(5'd31, "read_last");

      // Partial load from IDLE, ended by dropping load_en; access in LOAD is an error
      rst = 1'b1;
      #1;
      model_clear();
      check1("rst2_cpu_hold", cpu_hold, 1'b1);
      load_en = 1'b1;
      step();
      rst = 1'b0;
      step();
      check1("idle_to_load_ready", load_ready, 1'b1);
      for (int i = 0; i < 3; i++) begin
         load_valid = 1'b1;
         load_data  = 8'h11 * 8'(i + 1);
         model[i]   = 8'h11 * 8'(i + 1);
         step();
         load_valid = 1'b0;
         if (i == 0) begin
            check1("err_clear_before_bad_wr", err, 1'b0);
            wr = 1'b1; addr = 5'd10; data_in = 8'h99;
            step();
            wr = 1'b0;
            check1("err_wr_in_load", err, 1'b1);
         end
      end
      load_en = 1'b0;
      step();
      check1("partial_load_done", load_done, 1'b1);
      check1("partial_load_run", cpu_hold, 1'b0);
      step();
      check1("partial_load_done_low", load_done, 1'b0);
      for (int i = 0; i < 4; i++) do_read(5'(i), "read_partial");
      do_read(5'd10, "wr_in_load_ignored");

      // Write then read-after-write
      prev = data_out;
      addr = 5'd7; data_in = 8'h3C; wr = 1'b1;
      step();
      wr = 1'b0;
      model[7] = 8'h3C;
      check8("data_out_hold_on_wr", data_out, prev);
      do_read(5'd7, "read_after_write");

      // Fresh start, then simultaneous rd/wr
      rst = 1'b1;
      #1;
      model_clear();
      step();
      rst = 1'b0;
      step();
      check1("err_cleared_by_rst", err, 1'b0);
      do_read(5'd9, "read_before_conflict");
      prev = data_out;
      addr = 5'd2; data_in = 8'h55; rd = 1'b1; wr = 1'b1;
      step();
      rd = 1'b0; wr = 1'b0;
      model[2] = 8'h55;
      check8("conflict_read_suppressed", data_out, prev);
      check1("conflict_err", err, 1'b1);
      repeat (5) step();
      check1("err_sticky", err, 1'b1);
      check8("idle_data_out_hold", data_out, prev);
      do_read(5'd2, "conflict_write_done");

      // Reset in the middle of a load discards the partial program
      load_en = 1'b1;
      step();
      for (int i = 0; i < 10; i++) begin
         load_valid = 1'b1;
         load_data  = 8'h40 + 8'(i);
         step();
      end
      load_valid = 1'b0;
      check1("mid_load_ready", load_ready, 1'b1);
      rst = 1'b1;
      #1;
      model_clear();
      check1("abort_cpu_hold", cpu_hold, 1'b1);
      check1("abort_load_ready", load_ready, 1'b0);
      check1("abort_err", err, 1'b0);
      check1("abort_load_done", load_done, 1'b0);
      load_en = 1'b0;
      step();
      rst = 1'b0;
      step();
      check1("abort_then_run", cpu_hold, 1'b0);
      for (int i = 0; i < 10; i++) do_read(5'(i), "abort_mem_cleared");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
